// File: rtl/start_debounce.sv
// start_debounce: synchronizes and debounces a raw start button into a clean level,
// flagging aborted qualifications with a pulse and a saturating count.
module start_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int GLITCH_W        = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rstb,
  input  logic                i_Btn_Raw,
  output logic                o_Start,
  output logic                o_Glitch,
  output logic [GLITCH_W-1:0] o_Glitch_Cnt
);
  typedef enum logic [1:0] {S_LOW, S_QUAL_HIGH, S_HIGH, S_QUAL_LOW} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                glitch_q, glitch_d;
  logic [GLITCH_W-1:0] gcnt_q, gcnt_d;
  logic                w_sync;
  assign w_sync = sync_q[1];
  always_comb begin
    sync_d   = {sync_q[0], i_Btn_Raw};
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;
    case (state_q)
      S_LOW: if (w_sync) begin
        state_d = S_QUAL_HIGH;
        cnt_d   = '0;
      end
      S_QUAL_HIGH: if (!w_sync) begin
        state_d  = S_LOW;
        glitch_d = 1'b1;
      end else if (cnt_q == CNT_LAST) state_d = S_HIGH;
      else cnt_d = cnt_q + CNT_W'(1);
      S_HIGH: if (!w_sync) begin
        state_d = S_QUAL_LOW;
        cnt_d   = '0;
      end
      S_QUAL_LOW: if (w_sync) begin
        state_d  = S_HIGH;
        glitch_d = 1'b1;
      end else if (cnt_q == CNT_LAST) state_d = S_LOW;
      else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = S_LOW;
    endcase
    gcnt_d = (glitch_d && !(&gcnt_q)) ? gcnt_q + GLITCH_W'(1) : gcnt_q;
  end
  always_ff @(posedge i_Clk or negedge i_Rstb) begin
    if (!i_Rstb) begin
      state_q  <= S_LOW;
      sync_q   <= 2'b00;
      cnt_q    <= '0;
      glitch_q <= 1'b0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      gcnt_q   <= gcnt_d;
    end
  end
  // decoded from the state register alone so the level never glitches
  assign o_Start      = (state_q == S_HIGH) || (state_q == S_QUAL_LOW);
  assign o_Glitch     = glitch_q;
  assign o_Glitch_Cnt = gcnt_q;
endmodule

// File: tb/tb_start_debounce.sv
// tb_start_debounce: directed checks of start_debounce with DEBOUNCE_CYCLES=4, GLITCH_W=8.
module tb_start_debounce;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       raw = 1'b0;
  logic       start, glitch;
  logic [7:0] gcnt;
  int         vectors = 0;
  int         miscompares = 0;
  int         nglitch = 0;

  start_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .GLITCH_W(8)) dut (
    .i_Clk(clk), .i_Rstb(rst_n), .i_Btn_Raw(raw),
    .o_Start(start), .o_Glitch(glitch), .o_Glitch_Cnt(gcnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (glitch === 1'b1) nglitch++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    raw   = 1'b0;
    #3;
    vectors++;
    if ({start, glitch, gcnt} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_async: start=%b glitch=%b cnt=%0d required 0/0/0", start, glitch, gcnt);
    end
    step(2);
    rst_n = 1'b1;
    step(3);
    vectors++;
    if ({start, glitch, gcnt} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_idle: start=%b glitch=%b cnt=%0d required 0/0/0", start, glitch, gcnt);
    end
  endtask

  task automatic test_rise;
    int n0 = nglitch;
    raw = 1'b1;
    step(6);
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("FAIL rise_early: start=%b required 0", start);
    end
    step(1);
    vectors++;
    if (start !== 1'b1) begin
      miscompares++;
      $display("FAIL rise: start=%b required 1", start);
    end
    vectors++;
    if (nglitch != n0 || gcnt !== 8'd0) begin
      miscompares++;
      $display("FAIL rise_noglitch: pulses=%0d cnt=%0d required 0/0", nglitch - n0, gcnt);
    end
  endtask

  task automatic test_fall;
    int n0 = nglitch;
    raw = 1'b0;
    step(6);
    vectors++;
    if (start !== 1'b1) begin
      miscompares++;
      $display("FAIL fall_early: start=%b required 1", start);
    end
    step(1);
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("FAIL fall: start=%b required 0", start);
    end
    vectors++;
    if (nglitch != n0 || gcnt !== 8'd0) begin
      miscompares++;
      $display("FAIL fall_noglitch: pulses=%0d cnt=%0d required 0/0", nglitch - n0, gcnt);
    end
  endtask

  task automatic test_glitch_rise;
    int n0 = nglitch;
    raw = 1'b1;
    step(3);
    raw = 1'b0;
    step(1);
    raw = 1'b1;
    for (int k = 4; k <= 10; k++) begin
      step(1);
      vectors++;
      if (glitch !== (k == 5) || start !== (k == 10)) begin
        miscompares++;
        $display("FAIL glitch_rise edge E+%0d: glitch=%b start=%b required %b/%b",
                 k, glitch, start, k == 5, k == 10);
      end
    end
    vectors++;
    if (nglitch - n0 != 1 || gcnt !== 8'd1) begin
      miscompares++;
      $display("FAIL glitch_rise_count: pulses=%0d cnt=%0d required 1/1", nglitch - n0, gcnt);
    end
  endtask

  task automatic test_bounce_high;
    raw = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      step(1);
      if (k == 1) raw = 1'b1;
      vectors++;
      if (start !== 1'b1 || glitch !== (k == 4)) begin
        miscompares++;
        $display("FAIL bounce_high edge E+%0d: start=%b glitch=%b required 1/%b",
                 k, start, glitch, k == 4);
      end
    end
    vectors++;
    if (gcnt !== 8'd2) begin
      miscompares++;
      $display("FAIL bounce_high_count: cnt=%0d required 2", gcnt);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    raw = 1'b0;
    step(8);
    n0 = nglitch;
    for (int i = 0; i < 300; i++) begin
      raw = 1'b1;
      step(1);
      raw = 1'b0;
      step(1);
      vectors++;
      if (start !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_start iter %0d: start=%b required 0", i, start);
      end
    end
    step(4);
    vectors++;
    if (gcnt !== 8'd255) begin
      miscompares++;
      $display("FAIL b2b_saturate: cnt=%0d required 255", gcnt);
    end
    vectors++;
    if (nglitch - n0 != 300) begin
      miscompares++;
      $display("FAIL b2b_pulses: pulses=%0d required 300", nglitch - n0);
    end
  endtask

  task automatic test_reset_mid;
    raw = 1'b1;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({start, glitch, gcnt} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_mid: start=%b glitch=%b cnt=%0d required 0/0/0", start, glitch, gcnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("FAIL release_early: start=%b required 0", start);
    end
    step(1);
    vectors++;
    if (start !== 1'b1 || gcnt !== 8'd0) begin
      miscompares++;
      $display("FAIL release_rise: start=%b cnt=%0d required 1/0", start, gcnt);
    end
  endtask

  initial begin
    test_reset;
    test_rise;
    test_fall;
    test_glitch_rise;
    test_bounce_high;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
